// File: rtl/mul_pkg.sv
// Shared constants, opcode encodings and the scoreboard helper for the
// multiply/divide issue stage.
package mul_pkg;

  localparam int XLEN              = 32;
  localparam int RD_W              = 5;
  localparam int TAG_DEPTH_DEFAULT = 2;

  // Opcodes are forwarded to the unit untouched; listed here for reference.
  typedef enum logic [2:0] {
    OP_MUL    = 3'd0,
    OP_MULH   = 3'd1,
    OP_MULHSU = 3'd2,
    OP_MULHU  = 3'd3,
    OP_DIV    = 3'd4,
    OP_DIVU   = 3'd5,
    OP_REM    = 3'd6,
    OP_REMU   = 3'd7
  } mul_op_e;

  // One-hot of a destination register; x0 never counts as busy.
  function automatic logic [XLEN-1:0] rd_onehot(input logic [RD_W-1:0] rd);
    logic [XLEN-1:0] oh;
    oh     = {XLEN{1'b0}};
    oh[rd] = (rd != {RD_W{1'b0}});
    return oh;
  endfunction

endpackage

// File: rtl/mul_issue_chk.sv
// Protocol checker: a result offered while no tag is outstanding must never
// be acknowledged.
module mul_issue_chk (
  input logic clk,
  input logic rst,
  input logic mul_finished,
  input logic mul_ack,
  input logic tag_empty
);

  a_no_ack_without_tag: assert property (
    @(posedge clk) disable iff (!rst) (mul_finished && tag_empty) |-> !mul_ack
  );

endmodule

// File: rtl/mul_tag_fifo.sv
// Circular FIFO of destination tags for ops issued to the unit, oldest at
// the head. Per-entry valid/tag are exported for the busy scoreboard.
module mul_tag_fifo
  import mul_pkg::*;
#(
  parameter int DEPTH = TAG_DEPTH_DEFAULT
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       flush_i,
  input  logic                       push_i,
  input  logic [RD_W-1:0]            tag_i,
  input  logic                       pop_i,
  output logic                       full_o,
  output logic                       empty_o,
  output logic [RD_W-1:0]            head_o,
  output logic [DEPTH-1:0]           entry_valid_o,
  output logic [DEPTH-1:0][RD_W-1:0] entry_tag_o
);

  localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

  logic [PW-1:0]              wr_ptr_q, wr_ptr_d;
  logic [PW-1:0]              rd_ptr_q, rd_ptr_d;
  logic [DEPTH-1:0]           vld_q, vld_d;
  logic [DEPTH-1:0][RD_W-1:0] tag_q, tag_d;
  logic                       push_s, pop_s;

  // Pointer advance with explicit wrap so any DEPTH works.
  function automatic logic [PW-1:0] ptr_inc(input logic [PW-1:0] p);
    if (p == PW'(DEPTH - 1)) begin
      return {PW{1'b0}};
    end else begin
      return p + PW'(1'b1);
    end
  endfunction

  assign full_o        = &vld_q;
  assign empty_o       = ~|vld_q;
  assign head_o        = tag_q[rd_ptr_q];
  assign entry_valid_o = vld_q;
  assign entry_tag_o   = tag_q;

  // A push into a full FIFO is only legal when the head leaves that cycle.
  assign pop_s  = pop_i & ~empty_o;
  assign push_s = push_i & (~full_o | pop_s);

  // Next-state: flush wins, otherwise pop frees the head before push fills the tail.
  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    vld_d    = vld_q;
    tag_d    = tag_q;
    if (flush_i) begin
      wr_ptr_d = {PW{1'b0}};
      rd_ptr_d = {PW{1'b0}};
      vld_d    = {DEPTH{1'b0}};
    end else begin
      if (pop_s) begin
        vld_d[rd_ptr_q] = 1'b0;
        rd_ptr_d        = ptr_inc(rd_ptr_q);
      end else begin
        rd_ptr_d = rd_ptr_q;
      end
      if (push_s) begin
        vld_d[wr_ptr_q] = 1'b1;
        tag_d[wr_ptr_q] = tag_i;
        wr_ptr_d        = ptr_inc(wr_ptr_q);
      end else begin
        wr_ptr_d = wr_ptr_q;
      end
    end
  end

  // FIFO state registers.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      wr_ptr_q <= {PW{1'b0}};
      rd_ptr_q <= {PW{1'b0}};
      vld_q    <= {DEPTH{1'b0}};
      tag_q    <= {(DEPTH*RD_W){1'b0}};
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      vld_q    <= vld_d;
      tag_q    <= tag_d;
    end
  end

endmodule

// File: rtl/mul_issue.sv
// Issue stage between decode and an external multiply/divide unit: holds one
// op, tracks outstanding destinations in order, and stages results for
// writeback while exposing which registers are still pending.
module mul_issue
  import mul_pkg::*;
#(
  parameter int TAG_DEPTH = TAG_DEPTH_DEFAULT
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            clear_pipeline,
  input  logic            op_valid,
  input  logic [2:0]      op_para,
  input  logic [XLEN-1:0] op_rs0,
  input  logic [XLEN-1:0] op_rs1,
  input  logic [RD_W-1:0] op_rd,
  output logic            op_ready,
  output logic            mul_initial,
  output logic [2:0]      mul_para,
  output logic [XLEN-1:0] mul_rs0,
  output logic [XLEN-1:0] mul_rs1,
  input  logic            mul_ready,
  input  logic            mul_finished,
  input  logic [XLEN-1:0] mul_data,
  output logic            mul_ack,
  output logic            wb_valid,
  output logic [RD_W-1:0] wb_rd,
  output logic [XLEN-1:0] wb_data,
  input  logic            wb_ready,
  output logic [XLEN-1:0] busy_rd_mask
);

  logic                           issue_valid_q, issue_valid_d;
  logic [2:0]                     issue_para_q, issue_para_d;
  logic [XLEN-1:0]                issue_rs0_q, issue_rs0_d;
  logic [XLEN-1:0]                issue_rs1_q, issue_rs1_d;
  logic [RD_W-1:0]                issue_rd_q, issue_rd_d;
  logic                           wb_valid_q, wb_valid_d;
  logic [RD_W-1:0]                wb_rd_q, wb_rd_d;
  logic [XLEN-1:0]                wb_data_q, wb_data_d;
  logic                           issue_fire_s, op_accept_s, tag_pop_s;
  logic                           tag_full_s, tag_empty_s;
  logic [RD_W-1:0]                tag_head_s;
  logic [TAG_DEPTH-1:0]           tag_vld_s;
  logic [TAG_DEPTH-1:0][RD_W-1:0] tag_ent_s;
  logic [XLEN-1:0]                busy_s;

  // Request side: payload reads as zero whenever nothing is held.
  assign mul_initial  = issue_valid_q & ~clear_pipeline;
  assign mul_para     = issue_valid_q ? issue_para_q : 3'b000;
  assign mul_rs0      = issue_valid_q ? issue_rs0_q : {XLEN{1'b0}};
  assign mul_rs1      = issue_valid_q ? issue_rs1_q : {XLEN{1'b0}};
  assign issue_fire_s = mul_initial & mul_ready & (~tag_full_s | tag_pop_s);
  assign op_ready     = ~issue_valid_q | issue_fire_s;
  assign op_accept_s  = op_valid & op_ready & ~clear_pipeline;

  // Result side: only consume a result that has a tag and somewhere to go.
  assign mul_ack   = mul_finished & ~tag_empty_s & (~wb_valid_q | wb_ready) & ~clear_pipeline;
  assign tag_pop_s = mul_ack;

  assign wb_valid     = wb_valid_q;
  assign wb_rd        = wb_rd_q;
  assign wb_data      = wb_data_q;
  assign busy_rd_mask = busy_s;

  mul_tag_fifo #(.DEPTH(TAG_DEPTH)) u_tag_fifo (
    .clk          (clk),
    .rst          (rst),
    .flush_i      (clear_pipeline),
    .push_i       (issue_fire_s),
    .tag_i        (issue_rd_q),
    .pop_i        (tag_pop_s),
    .full_o       (tag_full_s),
    .empty_o      (tag_empty_s),
    .head_o       (tag_head_s),
    .entry_valid_o(tag_vld_s),
    .entry_tag_o  (tag_ent_s)
  );

  mul_issue_chk u_chk (
    .clk         (clk),
    .rst         (rst),
    .mul_finished(mul_finished),
    .mul_ack     (mul_ack),
    .tag_empty   (tag_empty_s)
  );

  // Issue register: flush drops it, a new op reloads it, a fire empties it.
  always_comb begin
    issue_valid_d = issue_valid_q;
    issue_para_d  = issue_para_q;
    issue_rs0_d   = issue_rs0_q;
    issue_rs1_d   = issue_rs1_q;
    issue_rd_d    = issue_rd_q;
    if (clear_pipeline) begin
      issue_valid_d = 1'b0;
    end else if (op_accept_s) begin
      issue_valid_d = 1'b1;
      issue_para_d  = op_para;
      issue_rs0_d   = op_rs0;
      issue_rs1_d   = op_rs1;
      issue_rd_d    = op_rd;
    end else if (issue_fire_s) begin
      issue_valid_d = 1'b0;
    end else begin
      issue_valid_d = issue_valid_q;
    end
  end

  // Writeback register: results for x0 are consumed without staging.
  always_comb begin
    wb_valid_d = wb_valid_q;
    wb_rd_d    = wb_rd_q;
    wb_data_d  = wb_data_q;
    if (clear_pipeline) begin
      wb_valid_d = 1'b0;
    end else if (mul_ack && (tag_head_s != {RD_W{1'b0}})) begin
      wb_valid_d = 1'b1;
      wb_rd_d    = tag_head_s;
      wb_data_d  = mul_data;
    end else if (wb_valid_q && wb_ready) begin
      wb_valid_d = 1'b0;
    end else begin
      wb_valid_d = wb_valid_q;
    end
  end

  // Pending-destination scoreboard over every stage that still owns an rd.
  always_comb begin
    busy_s = {XLEN{1'b0}};
    busy_s = busy_s | (issue_valid_q ? rd_onehot(issue_rd_q) : {XLEN{1'b0}});
    for (int i = 0; i < TAG_DEPTH; i++) begin
      busy_s = busy_s | (tag_vld_s[i] ? rd_onehot(tag_ent_s[i]) : {XLEN{1'b0}});
    end
    busy_s = busy_s | (wb_valid_q ? rd_onehot(wb_rd_q) : {XLEN{1'b0}});
  end

  // Issue and writeback state registers.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      issue_valid_q <= 1'b0;
      issue_para_q  <= 3'b000;
      issue_rs0_q   <= {XLEN{1'b0}};
      issue_rs1_q   <= {XLEN{1'b0}};
      issue_rd_q    <= {RD_W{1'b0}};
      wb_valid_q    <= 1'b0;
      wb_rd_q       <= {RD_W{1'b0}};
      wb_data_q     <= {XLEN{1'b0}};
    end else begin
      issue_valid_q <= issue_valid_d;
      issue_para_q  <= issue_para_d;
      issue_rs0_q   <= issue_rs0_d;
      issue_rs1_q   <= issue_rs1_d;
      issue_rd_q    <= issue_rd_d;
      wb_valid_q    <= wb_valid_d;
      wb_rd_q       <= wb_rd_d;
      wb_data_q     <= wb_data_d;
    end
  end

endmodule

// File: tb/tb_mul_issue.sv
// Randomised bench for mul_issue: the bench also plays the multiply/divide
// unit and keeps an in-order list of expected writebacks.
module tb_mul_issue;

  logic        clk, rst, clear_pipeline, op_valid;
  logic [2:0]  op_para;
  logic [31:0] op_rs0, op_rs1;
  logic [4:0]  op_rd;
  logic        op_ready, mul_initial;
  logic [2:0]  mul_para;
  logic [31:0] mul_rs0, mul_rs1;
  logic        mul_ready, mul_finished;
  logic [31:0] mul_data;
  logic        mul_ack, wb_valid;
  logic [4:0]  wb_rd;
  logic [31:0] wb_data;
  logic        wb_ready;
  logic [31:0] busy_rd_mask;

  mul_issue #(.TAG_DEPTH(2)) dut (
    .clk(clk), .rst(rst), .clear_pipeline(clear_pipeline),
    .op_valid(op_valid), .op_para(op_para), .op_rs0(op_rs0), .op_rs1(op_rs1),
    .op_rd(op_rd), .op_ready(op_ready),
    .mul_initial(mul_initial), .mul_para(mul_para), .mul_rs0(mul_rs0),
    .mul_rs1(mul_rs1), .mul_ready(mul_ready), .mul_finished(mul_finished),
    .mul_data(mul_data), .mul_ack(mul_ack),
    .wb_valid(wb_valid), .wb_rd(wb_rd), .wb_data(wb_data), .wb_ready(wb_ready),
    .busy_rd_mask(busy_rd_mask)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct { logic [4:0] rd; logic [31:0] data; } wb_t;
  typedef struct { int t; logic [31:0] d; } unit_t;

  wb_t   exp_q[$];
  wb_t   wb_log[$];
  unit_t uq[$];
  int    n_pass = 0, n_checks = 0, cyc = 0;
  int    unit_lat = 2, unit_cap = 2;
  logic  rdy_en = 1'b1, flush_unit_on_clear = 1'b1;
  logic  s_op_ready, s_mul_initial, s_ack, s_wb_valid, s_acc;
  logic [2:0]  s_mul_para;
  logic [31:0] s_mul_rs0, s_mul_rs1, s_mask;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %h expected %h", tag, got, exp);
  endtask

  // Architectural result of a RISC-V M-extension op.
  function automatic logic [31:0] ref_op(input logic [2:0] p, input logic [31:0] a, input logic [31:0] b);
    logic [63:0] sa, sb, za, zb, pr;
    sa = {{32{a[31]}}, a}; sb = {{32{b[31]}}, b};
    za = {32'd0, a};       zb = {32'd0, b};
    case (p)
      3'd0: begin pr = za * zb; return pr[31:0]; end
      3'd1: begin pr = sa * sb; return pr[63:32]; end
      3'd2: begin pr = sa * zb; return pr[63:32]; end
      3'd3: begin pr = za * zb; return pr[63:32]; end
      3'd4: if (b == 32'd0) return 32'hFFFF_FFFF;
            else if (a == 32'h8000_0000 && b == 32'hFFFF_FFFF) return a;
            else return $signed(a) / $signed(b);
      3'd5: return (b == 32'd0) ? 32'hFFFF_FFFF : a / b;
      3'd6: if (b == 32'd0) return a;
            else if (a == 32'h8000_0000 && b == 32'hFFFF_FFFF) return 32'd0;
            else return $signed(a) % $signed(b);
      default: return (b == 32'd0) ? a : a % b;
    endcase
  endfunction

  function automatic logic [31:0] model_mask();
    logic [31:0] m = 32'd0;
    foreach (exp_q[i]) m[exp_q[i].rd] = 1'b1;
    m[0] = 1'b0;
    return m;
  endfunction

  task automatic drive_unit();
    mul_ready = (uq.size() < unit_cap) && rdy_en;
    if (uq.size() != 0 && cyc >= uq[0].t) begin
      mul_finished = 1'b1; mul_data = uq[0].d;
    end else begin
      mul_finished = 1'b0; mul_data = 32'd0;
    end
  endtask

  // One clock: observe at negedge, update model/unit at posedge, redrive unit.
  task automatic cycle();
    logic acc, fire, ack, wbhs;
    logic [31:0] fire_res;
    @(negedge clk);
    s_op_ready = op_ready; s_mul_initial = mul_initial; s_mul_para = mul_para;
    s_mul_rs0 = mul_rs0; s_mul_rs1 = mul_rs1; s_mask = busy_rd_mask;
    s_ack = mul_ack; s_wb_valid = wb_valid;
    acc  = op_valid & op_ready & ~clear_pipeline;
    fire = mul_initial & mul_ready;
    ack  = mul_ack;
    wbhs = wb_valid & wb_ready;
    s_acc = acc;
    fire_res = ref_op(mul_para, mul_rs0, mul_rs1);
    chk("busy_mask", busy_rd_mask, model_mask());
    if (ack) chk("ack_without_finish", {31'd0, mul_finished}, 32'd1);
    if (wbhs) begin
      chk("wb_has_expect", 32'(exp_q.size() != 0), 32'd1);
      if (exp_q.size() != 0) begin
        chk("wb_rd", {27'd0, wb_rd}, {27'd0, exp_q[0].rd});
        chk("wb_data", wb_data, exp_q[0].data);
      end
      wb_log.push_back('{wb_rd, wb_data});
    end
    @(posedge clk);
    cyc++;
    if (clear_pipeline) begin
      exp_q.delete();
    end else begin
      if (wbhs && exp_q.size() != 0) void'(exp_q.pop_front());
      if (acc && op_rd != 5'd0) exp_q.push_back('{op_rd, ref_op(op_para, op_rs0, op_rs1)});
    end
    if (ack && uq.size() != 0) void'(uq.pop_front());
    if (fire) uq.push_back('{cyc + unit_lat, fire_res});
    if (clear_pipeline && flush_unit_on_clear) uq.delete();
    #1;
    drive_unit();
  endtask

  task automatic issue_op(input logic [2:0] p, input logic [31:0] a, input logic [31:0] b, input logic [4:0] rd);
    int n = 0;
    op_valid = 1'b1; op_para = p; op_rs0 = a; op_rs1 = b; op_rd = rd;
    do begin cycle(); n++; end while (!s_acc && n < 50);
    chk("op_accept_timeout", 32'(s_acc), 32'd1);
  endtask

  task automatic wait_wb(input int cnt);
    int n = 0;
    while (wb_log.size() < cnt && n < 100) begin cycle(); n++; end
    chk("wb_count", wb_log.size(), cnt);
  endtask

  initial begin
    int saw_ack, saw_wb, mask_or;
    rst = 1'b0; clear_pipeline = 1'b0; op_valid = 1'b0; op_para = 3'd0;
    op_rs0 = 32'd0; op_rs1 = 32'd0; op_rd = 5'd0; wb_ready = 1'b1;
    drive_unit();
    #12;
    chk("rst_op_ready", 32'(op_ready), 32'd1);
    chk("rst_mul_initial", 32'(mul_initial), 32'd0);
    chk("rst_wb_valid", 32'(wb_valid), 32'd0);
    chk("rst_mask", busy_rd_mask, 32'd0);
    #5 rst = 1'b1;

    // Single MUL 3*5 -> x7.
    unit_lat = 2;
    issue_op(3'd0, 32'd3, 32'd5, 5'd7);
    op_valid = 1'b0;
    cycle();
    chk("mul_initial_lat", 32'(s_mul_initial), 32'd1);
    chk("mul_para", {29'd0, s_mul_para}, 32'd0);
    chk("mul_rs0", s_mul_rs0, 32'd3);
    chk("mul_rs1", s_mul_rs1, 32'd5);
    chk("busy7_issued", 32'(s_mask[7]), 32'd1);
    wb_log.delete();
    wait_wb(1);
    if (wb_log.size() >= 1) begin
      chk("d021_rd", {27'd0, wb_log[0].rd}, 32'd7);
      chk("d021_data", wb_log[0].data, 32'd15);
    end
    cycle();
    chk("busy7_cleared", s_mask, 32'd0);

    // Back-pressure: FIFO fills, third op stalls, order kept.
    unit_lat = 6; wb_ready = 1'b0; wb_log.delete();
    issue_op(3'd0, 32'd2, 32'd2, 5'd1);
    issue_op(3'd0, 32'd3, 32'd3, 5'd2);
    issue_op(3'd0, 32'd4, 32'd4, 5'd3);
    op_valid = 1'b0;
    cycle();
    chk("stall_op_ready", 32'(s_op_ready), 32'd0);
    chk("stall_mul_initial", 32'(s_mul_initial), 32'd1);
    repeat (20) cycle();
    wb_ready = 1'b1;
    wait_wb(3);
    for (int i = 0; i < 3 && i < wb_log.size(); i++)
      chk("order_rd", {27'd0, wb_log[i].rd}, 32'(i + 1));

    // Divide-by-zero results.
    unit_lat = 2; wb_log.delete();
    issue_op(3'd5, 32'd7, 32'd0, 5'd4);
    issue_op(3'd7, 32'd7, 32'd0, 5'd5);
    op_valid = 1'b0;
    wait_wb(2);
    if (wb_log.size() >= 2) begin
      chk("divu_by0", wb_log[0].data, 32'hFFFF_FFFF);
      chk("remu_by0", wb_log[1].data, 32'd7);
    end

    // Result for x0 is acked and dropped.
    issue_op(3'd0, 32'd9, 32'd9, 5'd0);
    op_valid = 1'b0;
    saw_ack = 0; saw_wb = 0; mask_or = 0;
    repeat (12) begin
      cycle();
      saw_ack |= 32'(s_ack); saw_wb |= 32'(s_wb_valid); mask_or |= s_mask;
    end
    chk("x0_ack", saw_ack, 32'd1);
    chk("x0_no_wb", saw_wb, 32'd0);
    chk("x0_mask", mask_or, 32'd0);

    // Flush with one op in flight; the late result must not be acked.
    unit_lat = 5; flush_unit_on_clear = 1'b0;
    issue_op(3'd0, 32'd6, 32'd7, 5'd9);
    op_valid = 1'b0;
    cycle();
    clear_pipeline = 1'b1;
    cycle();
    clear_pipeline = 1'b0;
    cycle();
    chk("clr_wb_valid", 32'(s_wb_valid), 32'd0);
    chk("clr_mask", s_mask, 32'd0);
    chk("clr_op_ready", 32'(s_op_ready), 32'd1);
    saw_ack = 0;
    repeat (10) begin cycle(); saw_ack |= 32'(s_ack); end
    chk("clr_late_no_ack", saw_ack, 32'd0);
    uq.delete(); drive_unit(); flush_unit_on_clear = 1'b1;

    // Asynchronous reset with two ops outstanding.
    unit_lat = 8;
    issue_op(3'd1, 32'd5, 32'd6, 5'd10);
    issue_op(3'd4, 32'd50, 32'd6, 5'd11);
    op_valid = 1'b0;
    cycle();
    #2 rst = 1'b0;
    #1;
    chk("arst_op_ready", 32'(op_ready), 32'd1);
    chk("arst_mul_initial", 32'(mul_initial), 32'd0);
    chk("arst_mul_para", {29'd0, mul_para}, 32'd0);
    chk("arst_mul_rs0", mul_rs0, 32'd0);
    chk("arst_mul_rs1", mul_rs1, 32'd0);
    chk("arst_mul_ack", 32'(mul_ack), 32'd0);
    chk("arst_wb_valid", 32'(wb_valid), 32'd0);
    chk("arst_wb_rd", {27'd0, wb_rd}, 32'd0);
    chk("arst_wb_data", wb_data, 32'd0);
    chk("arst_mask", busy_rd_mask, 32'd0);
    exp_q.delete(); uq.delete(); drive_unit();
    #3 rst = 1'b1;

    // Random traffic against the in-order model.
    for (int k = 0; k < 600; k++) begin
      op_valid = ($urandom_range(0, 2) != 0);
      op_para  = 3'($urandom_range(0, 7));
      op_rs0   = $urandom;
      op_rs1   = ($urandom_range(0, 9) == 0) ? 32'd0 : $urandom;
      op_rd    = ($urandom_range(0, 7) == 0) ? 5'd0 : 5'($urandom_range(1, 31));
      wb_ready = ($urandom_range(0, 9) < 7);
      rdy_en   = ($urandom_range(0, 9) < 8);
      unit_lat = $urandom_range(1, 4);
      clear_pipeline = ($urandom_range(0, 49) == 0);
      drive_unit();
      cycle();
    end
    op_valid = 1'b0; clear_pipeline = 1'b0; wb_ready = 1'b1; rdy_en = 1'b1;
    drive_unit();
    for (int k = 0; k < 200 && (exp_q.size() != 0 || uq.size() != 0); k++) cycle();
    chk("drain_exp_empty", exp_q.size(), 32'd0);
    chk("drain_unit_empty", uq.size(), 32'd0);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule

// File: doc/mul_issue.md
MUL_ISSUE -- requirements
Module: mul_issue

Interface
REQ-001 Parameters SHALL be:
- TAG_DEPTH, default 2: depth of the outstanding-tag FIFO; power of two, >=1.
- XLEN, fixed 32: data width.
REQ-002 Ports SHALL be:
- clk  in  1  single clock; all state on rising edge.
- rst  in  1  reset; asynchronous, active-low (0 = reset).
- clear_pipeline  in  1  pipeline flush.
- op_valid  in  1  decode offers a MUL/DIV op.
- op_para  in  3  operation code.
- op_rs0  in  32  first operand.
- op_rs1  in  32  second operand.
- op_rd  in  5  destination register.
- op_ready  out  1  op accepted when op_valid&op_ready.
- mul_initial  out  1  request to multiplier/divider.
- mul_para  out  3  request opcode.
- mul_rs0  out  32  request operand 0.
- mul_rs1  out  32  request operand 1.
- mul_ready  in  1  unit idle.
- mul_finished  in  1  unit result available.
- mul_data  in  32  unit result.
- mul_ack  out  1  result consumed.
- wb_valid  out  1  writeback request.
- wb_rd  out  5  writeback register.
- wb_data  out  32  writeback value.
- wb_ready  in  1  register file accepts.
- busy_rd_mask  out  32  pending-destination scoreboard.

Function
REQ-003 Issue register (valid, para, rs0, rs1, rd) SHALL load on op_valid&op_ready; op_ready = ~issue_valid | issue_fire.
REQ-004 mul_initial SHALL equal issue_valid & ~clear_pipeline; mul_para/rs0/rs1 SHALL come directly from the issue register; zero when issue_valid=0.
REQ-005 issue_fire = mul_initial & mul_ready & (tag FIFO not full | tag_pop); on fire, issue_valid clears (unless reloaded the same cycle) and rd is pushed into the tag FIFO.
REQ-006 Latency: op accepted in cycle N SHALL present mul_initial in cycle N+1.
REQ-007 mul_ack = mul_finished & tag FIFO non-empty & (~wb_valid | wb_ready) & ~clear_pipeline; tag_pop = mul_ack.
REQ-008 On mul_ack with head tag != 0, the wb register SHALL load {head tag, mul_data}, so wb_valid rises the next cycle.
REQ-009 On mul_ack with head tag == 0, the result SHALL be popped and discarded; wb_valid is not set by that result.
REQ-010 wb_valid/wb_rd/wb_data SHALL hold stable until wb_valid&wb_ready; a new load in the same cycle replaces the entry.
REQ-011 Results SHALL be retired in issue order; the tag FIFO never reorders entries.
REQ-012 mul_finished with an empty tag FIFO SHALL NOT be acked (protocol error; assertion only).
REQ-013 busy_rd_mask SHALL be the OR of one-hot(rd) for the valid issue register, each valid FIFO entry and the valid wb register; bit 0 is always 0; combinational from state.
REQ-014 Simultaneous push and pop on a full FIFO SHALL be allowed and keep the count unchanged; pointers wrap modulo TAG_DEPTH.
REQ-015 clear_pipeline SHALL, at the next edge, clear issue_valid, empty the tag FIFO and clear wb_valid; op acceptance in the clear cycle is ignored.
REQ-016 op_para encodings: 0 MUL, 1-3 MULH/MULHSU/MULHU, 4 DIV, 5 DIVU, 6 REM, 7 REMU; passed through unmodified.

Reset
REQ-017 While rst=0, all state SHALL clear asynchronously. Outputs then read: op_ready=1; mul_initial=0, mul_para=0, mul_rs0=0, mul_rs1=0; mul_ack=0; wb_valid=0, wb_rd=0, wb_data=0; busy_rd_mask=0.
REQ-018 Reset asserted mid-operation SHALL drop all outstanding tags without further handshakes.

Structure
REQ-019 Package mul_pkg SHALL hold XLEN, the op_para encodings and the TAG_DEPTH default.
REQ-020 The tag FIFO SHALL be a sub-module mul_tag_fifo (push, pop, full, empty, head and per-entry valid/data for the scoreboard).

Verification
REQ-021 MUL rs0=3, rs1=5, rd=7 -> mul_initial with para 0 one cycle after acceptance; wb_rd=7, wb_data=15; busy_rd_mask[7]=1 from acceptance until the wb handshake.
REQ-022 Three back-to-back ops (rd 1,2,3) with wb_ready=0 -> third op stalls (op_ready=0) once FIFO full and unit busy; after wb_ready=1, writebacks occur in order 1,2,3.
REQ-023 DIVU rs0=7, rs1=0, rd=4 -> wb_data=0xFFFFFFFF; REMU same operands, rd=5 -> wb_data=7.
REQ-024 MUL rd=0 -> mul_ack pulses, wb_valid stays 0, busy_rd_mask stays 0.
REQ-025 clear_pipeline with one op in flight -> next cycle: FIFO empty, wb_valid=0, busy_rd_mask=0, op_ready=1; late mul_finished is not acked.
REQ-026 rst driven low between clock edges with two ops outstanding -> outputs at reset values immediately, before the next clk edge.
